// File: rtl/fir_pkg.sv
// Shared sizes, FSM encoding and fixed-point constants for the serial-MAC FIR.
package fir_pkg;

    localparam int unsigned NTAPS  = 31;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned FRAC_W = 13;
    localparam int unsigned ACC_W  = 40;
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned TAP_W  = $clog2(NTAPS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } fir_state_e;

    // Half an LSB of the Q2.13 output, added before the arithmetic shift
    localparam logic signed [ACC_W-1:0] ROUND_C = ACC_W'(1) << (FRAC_W - 1);

    localparam logic signed [ACC_W-1:0]  SAT_HI  = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0]  SAT_LO  = ACC_W'(-32768);
    localparam logic signed [DATA_W-1:0] OUT_MAX = 16'sh7FFF;
    localparam logic signed [DATA_W-1:0] OUT_MIN = 16'sh8000;

endpackage

// File: rtl/fir_sample_ring.sv
// Circular sample delay line; wptr always points at the newest sample.
module fir_sample_ring
    import fir_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic signed [DATA_W-1:0] wr_data,
    input  logic        [TAP_W-1:0]  tap,
    output logic signed [DATA_W-1:0] rd_data_c
);

    logic signed [DATA_W-1:0] mem [NTAPS];
    logic        [TAP_W-1:0]  wptr;
    logic        [TAP_W-1:0]  wptr_nxt_c;
    logic        [TAP_W-1:0]  rd_idx_c;

    // Modulo-NTAPS pointer arithmetic; the wrap term is exact in TAP_W bits
    always_comb begin
        wptr_nxt_c = (wptr == TAP_W'(NTAPS - 1)) ? '0 : wptr + TAP_W'(1);
        if (wptr >= tap) begin
            rd_idx_c = wptr - tap;
        end else begin
            rd_idx_c = wptr + TAP_W'(NTAPS) - tap;
        end
    end

    assign rd_data_c = mem[rd_idx_c];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            for (int i = 0; i < NTAPS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            wptr             <= wptr_nxt_c;
            mem[wptr_nxt_c]  <= wr_data;
        end
    end

endmodule

// File: rtl/fir_serial_mac.sv
// 31-tap FIR using one multiply-accumulate stepped over all taps (33 cycles/output).
module fir_serial_mac
    import fir_pkg::*;
(
    input  logic                            clk,
    input  logic                            reset,
    input  logic        [NTAPS*DATA_W-1:0]  coef_flat,
    input  logic signed [DATA_W-1:0]        sample_in,
    input  logic                            sample_valid,
    output logic signed [DATA_W-1:0]        data_out,
    output logic                            data_out_valid,
    output logic                            busy,
    output logic                            overrun
);

    fir_state_e               state, state_n;
    logic        [TAP_W-1:0]  tap, tap_n;
    logic signed [ACC_W-1:0]  acc, acc_n;
    logic signed [DATA_W-1:0] data_out_n;
    logic                     data_out_valid_n;
    logic                     busy_n;
    logic                     overrun_n;

    logic                     wr_en_c;
    logic signed [DATA_W-1:0] x_c;
    logic signed [DATA_W-1:0] coef_c;
    logic signed [PROD_W-1:0] prod_c;
    logic signed [ACC_W-1:0]  rnd_c;
    logic signed [DATA_W-1:0] coef_arr [NTAPS];

    fir_sample_ring u_ring (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en_c),
        .wr_data   (sample_in),
        .tap       (tap),
        .rd_data_c (x_c)
    );

    // Coefficient mux
    always_comb begin
        for (int k = 0; k < NTAPS; k++) begin
            coef_arr[k] = coef_flat[k*DATA_W +: DATA_W];
        end
    end

    assign coef_c = coef_arr[tap];
    assign prod_c = PROD_W'(x_c) * PROD_W'(coef_c);
    assign rnd_c  = (acc + ROUND_C) >>> FRAC_W;

    // Next-state and registered-output logic
    always_comb begin
        state_n          = state;
        tap_n            = tap;
        acc_n            = acc;
        data_out_n       = data_out;
        data_out_valid_n = 1'b0;
        busy_n           = busy;
        overrun_n        = 1'b0;
        wr_en_c          = 1'b0;

        case (state)
            IDLE: begin
                if (sample_valid) begin
                    wr_en_c = 1'b1;
                    acc_n   = '0;
                    tap_n   = '0;
                    busy_n  = 1'b1;
                    state_n = MAC;
                end
            end
            MAC: begin
                overrun_n = sample_valid;
                acc_n     = acc + ACC_W'(prod_c);
                if (tap == TAP_W'(NTAPS - 1)) begin
                    tap_n   = '0;
                    state_n = DONE;
                end else begin
                    tap_n = tap + TAP_W'(1);
                end
            end
            DONE: begin
                overrun_n        = sample_valid;
                data_out_valid_n = 1'b1;
                busy_n           = 1'b0;
                state_n          = IDLE;
                if (rnd_c > SAT_HI) begin
                    data_out_n = OUT_MAX;
                end else if (rnd_c < SAT_LO) begin
                    data_out_n = OUT_MIN;
                end else begin
                    data_out_n = DATA_W'(rnd_c);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            tap            <= '0;
            acc            <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            busy           <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            state          <= state_n;
            tap            <= tap_n;
            acc            <= acc_n;
            data_out       <= data_out_n;
            data_out_valid <= data_out_valid_n;
            busy           <= busy_n;
            overrun        <= overrun_n;
        end
    end

endmodule

// File: tb/tb_fir_serial_mac.sv
// Self-checking bench for fir_serial_mac: scoreboard against an integer FIR model plus corner sequences.
module tb_fir_serial_mac;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [495:0] coef_flat = '0;
    logic [15:0]  sample_in = '0;
    logic         sample_valid = 1'b0;
    logic [15:0]  data_out;
    logic         data_out_valid;
    logic         busy;
    logic         overrun;

    always #5 clk = ~clk;

    fir_serial_mac dut (
        .clk            (clk),
        .reset          (reset),
        .coef_flat      (coef_flat),
        .sample_in      (sample_in),
        .sample_valid   (sample_valid),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .busy           (busy),
        .overrun        (overrun)
    );

    typedef struct {
        logic [15:0] val;
        int          acc;
    } exp_t;

    typedef struct {
        logic [15:0] s;
        logic [15:0] e;
    } rvec_t;

    localparam logic [15:0] COEF_BLK [31] = '{
        16'hFFD2, 16'hFFFA, 16'h0045, 16'h0021, 16'hFF8C, 16'hFFB0, 16'h00D8, 16'h0096,
        16'hFE70, 16'hFED4, 16'h02A8, 16'h0226, 16'hFB7C, 16'hFCF0, 16'h0890, 16'h0B40,
        16'h0890, 16'hFCF0, 16'hFB7C, 16'h0226, 16'h02A8, 16'hFED4, 16'hFE70, 16'h0096,
        16'h00D8, 16'hFFB0, 16'hFF8C, 16'h0021, 16'h0045, 16'hFFFA, 16'hFFD2
    };

    exp_t        exp_q [$];
    logic [15:0] got_q [$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          ovr_cnt = 0;
    int          vld_cnt = 0;
    int          hist [31];
    int          h    [31];
    rvec_t       rtab [5];

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] model_y();
        longint a = 0;
        for (int k = 0; k < 31; k++) begin
            a += longint'(h[k]) * longint'(hist[k]);
        end
        a = (a + 64'sd4096) >>> 13;
        if (a > 32767) a = 32767;
        else if (a < -32768) a = -32768;
        return a[15:0];
    endfunction

    task automatic model_push(input logic [15:0] s);
        for (int k = 30; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = int'($signed(s));
    endtask

    task automatic model_clear();
        for (int k = 0; k < 31; k++) hist[k] = 0;
        exp_q.delete();
    endtask

    // One clock: sample outputs 1 time unit after the rising edge
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (data_out_valid === 1'b1) begin
            vld_cnt++;
            got_q.push_back(data_out);
            if (exp_q.size() == 0) begin
                check("spurious_valid", 40'(data_out_valid), 40'd0);
            end else begin
                e = exp_q.pop_front();
                check("data", 40'(data_out), 40'(e.val));
                check("latency", 40'(cyc - e.acc), 40'd32);
            end
        end
        if (overrun === 1'b1) ovr_cnt++;
    endtask

    task automatic set_coefs(input int mode);
        logic [15:0] w;
        for (int k = 0; k < 31; k++) begin
            case (mode)
                0:       w = COEF_BLK[k];
                1:       w = (k == 0) ? 16'h0001 : 16'h0000;
                default: w = 16'h7FFF;
            endcase
            coef_flat[16*k +: 16] = w;
            h[k] = int'($signed(w));
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
        model_clear();
    endtask

    // Offer a sample at the first cycle the DUT can take it
    task automatic send(input logic [15:0] s);
        int n = 0;
        while (busy !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        if (busy !== 1'b0) check("send_timeout", 40'(busy), 40'd0);
        sample_in    = s;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        model_push(s);
        exp_q.push_back('{model_y(), cyc});
        check("busy_after_accept", 40'(busy), 40'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 40'(exp_q.size()), 40'd0);
        exp_q.delete();
    endtask

    task automatic impulse_run(input string name);
        got_q.delete();
        send(16'h2000);
        repeat (30) send(16'h0000);
        drain();
        check({name, "_count"}, 40'(got_q.size()), 40'd31);
        for (int k = 0; k < 31; k++) begin
            check(name, (k < got_q.size()) ? 40'(got_q[k]) : 'x, 40'(COEF_BLK[k]));
        end
    endtask

    initial begin
        int o0;
        int v0;

        // Reset with a simultaneous sample offer: reset must win
        set_coefs(0);
        model_clear();
        sample_in    = 16'h7FFF;
        sample_valid = 1'b1;
        repeat (3) tick();
        reset        = 1'b0;
        sample_valid = 1'b0;
        check("rst_data_out", 40'(data_out), 40'h0000);
        check("rst_valid", 40'(data_out_valid), 40'd0);
        check("rst_busy", 40'(busy), 40'd0);
        check("rst_overrun", 40'(overrun), 40'd0);
        tick();
        check("rst_busy_after", 40'(busy), 40'd0);
        repeat (100) tick();
        check("idle_no_valid", 40'(vld_cnt), 40'd0);

        // Impulse response equals the coefficient words
        impulse_run("impulse");

        // Rounding table with a single unit tap
        rtab[0] = '{16'h1000, 16'h0001};
        rtab[1] = '{16'h0FFF, 16'h0000};
        rtab[2] = '{16'hF000, 16'h0000};
        rtab[3] = '{16'hEFFF, 16'hFFFF};
        rtab[4] = '{16'h2000, 16'h0001};
        set_coefs(1);
        do_reset(2);
        for (int i = 0; i < 5; i++) begin
            got_q.delete();
            send(rtab[i].s);
            drain();
            check("round", (got_q.size() > 0) ? 40'(got_q[$]) : 'x, 40'(rtab[i].e));
        end

        // Saturation at both rails
        set_coefs(2);
        do_reset(2);
        got_q.delete();
        repeat (31) send(16'h7FFF);
        drain();
        check("sat_pos", (got_q.size() > 0) ? 40'(got_q[$]) : 'x, 40'h7FFF);
        got_q.delete();
        repeat (31) send(16'h8000);
        drain();
        check("sat_neg", (got_q.size() > 0) ? 40'(got_q[$]) : 'x, 40'h8000);

        // Overrun: sample offered at E0+5 is dropped
        set_coefs(0);
        do_reset(2);
        o0 = ovr_cnt;
        send(16'h1234);
        repeat (4) tick();
        sample_in    = 16'h4000;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        check("overrun_pulse", 40'(overrun), 40'd1);
        tick();
        check("overrun_single", 40'(overrun), 40'd0);
        drain();
        check("overrun_count", 40'(ovr_cnt - o0), 40'd1);
        send(16'h0800);
        drain();

        // Reset at E0+10 aborts the computation and clears the delay line
        send(16'h3000);
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_clear();
        check("abort_busy", 40'(busy), 40'd0);
        check("abort_valid", 40'(data_out_valid), 40'd0);
        v0 = vld_cnt;
        repeat (40) tick();
        check("abort_no_valid", 40'(vld_cnt - v0), 40'd0);
        impulse_run("impulse_after_abort");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
        $fatal(1);
    end

endmodule

// File: doc/fir_serial_mac.md
# fir_serial_mac

Time-multiplexed 31-tap FIR filter that consumes the fixed Q2.13 coefficient set produced by the inverse-impulse-response coefficient block, one 16-bit word per tap, and applies it to the incoming sample stream. It sits directly downstream of the coefficient block and upstream of the demodulator/decision logic. It uses a single multiply-accumulate unit stepped over all taps, so one output costs 33 clock cycles.

## Interface
- NTAPS, 31: number of taps and delay-line depth.
- DATA_W, 16: sample, coefficient and output width, all signed two's complement.
- FRAC_W, 13: fractional bits, Q2.13.
- ACC_W, 40: accumulator width.
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high.
- coef_flat  in  NTAPS*DATA_W  coefficients; bits [16k+15:16k] hold tap k, which is coefficient word k+1. Static after reset.
- sample_in  in  DATA_W  new sample, Q2.13.
- sample_valid  in  1  sample_in is offered this cycle.
- data_out  out  DATA_W  filtered sample, Q2.13, registered.
- data_out_valid  out  1  single-cycle pulse; data_out is new.
- busy  out  1  high while a computation is in progress; samples are not accepted.
- overrun  out  1  single-cycle pulse; a sample was dropped.

## Operation
- y[n] = Σ_{k=0}^{30} h[k]·x[n−k], where h[k] = coef_flat tap k.
- Delay line: 31-entry circular buffer with a write pointer. Writing the newest sample overwrites the oldest. The pointer wraps from 30 to 0.
- FSM states:
  - IDLE: if sample_valid, write sample_in, clear acc, set tap=0, go to MAC.
  - MAC: acc += x[n−tap]·h[tap]; tap++. After tap 30, go to DONE.
  - DONE: round, saturate, register data_out, pulse data_out_valid, go to IDLE.
- Arithmetic:
  - Product is 32-bit signed Q4.26, sign-extended to ACC_W.
  - Result = (acc + 2^12) >>> 13, arithmetic shift.
  - Saturate to [−32768, 32767], i.e. 0x8000 to 0x7FFF.
- Samples offered while busy=1 are dropped and produce an overrun pulse in the following cycle. There is no queuing.
- Reset values:
  - State IDLE, tap 0, write pointer 0.
  - All delay-line entries 0, acc 0.
  - data_out 0x0000, data_out_valid 0, busy 0, overrun 0.
- Reset mid-operation aborts the computation. No data_out_valid is produced. The delay line is zeroed.

## Timing
- Accept edge E0: sample_valid=1 in IDLE. busy is high from the cycle after E0.
- Edges E1–E31: one MAC per edge, taps 0..30.
- Edge E32: data_out updates. data_out_valid=1 for the one cycle after E32. busy falls in the same cycle.
- A new sample can be accepted at E33 at the earliest. Maximum throughput is 1 sample per 33 cycles.
- sample_valid high in IDLE is always accepted; there is no ready input.
- Simultaneous reset and sample_valid: reset wins and the sample is discarded.

## Structure
- Shared package fir_pkg holds:
  - NTAPS, DATA_W, FRAC_W, ACC_W;
  - the FSM state enum (IDLE, MAC, DONE);
  - the rounding constant 1<<(FRAC_W−1);
  - the saturation limits.
- One sub-module, fir_sample_ring: circular delay line with write port, write pointer, and a combinational read port addressed by (wptr − tap) mod NTAPS.
- The coefficient mux, MAC, rounding/saturation and FSM stay in the top level.

## Test plan
- Reset: after reset, data_out=0x0000, data_out_valid=0, busy=0, overrun=0. No valid pulse for 100 idle cycles.
- Impulse: coef_flat from the coefficient block. Input 0x2000 then 30 × 0x0000, each sample offered at the first cycle it is accepted. The 31 outputs equal the coefficient words in order: 0xFFD2, 0xFFFA, 0x0045, …, 0x0B40 (output 16), …, 0xFFD2. Each valid pulse arrives 32 edges after its accept.
- Rounding: tap 0 = 0x0001, all other taps 0.
  - Sample 0x1000 gives output 0x0001.
  - Sample 0x0FFF gives output 0x0000.
  - Sample 0xF000 gives output 0x0000.
- Saturation: all taps 0x7FFF.
  - 31 samples of 0x7FFF settle to output 0x7FFF.
  - 31 samples of 0x8000 settle to output 0x8000.
- Overrun: offer a sample at E0+5.
  - One overrun pulse occurs in the following cycle.
  - The sample is dropped.
  - The output matches a model that excludes the sample.
- Reset at E0+10 mid-MAC:
  - No data_out_valid.
  - busy=0 the cycle after reset.
  - A subsequent impulse reproduces the coefficient sequence exactly, proving the delay line was cleared.
